// File: rtl/qr_result_collector_if.sv
`default_nettype none
// ============================================================================
// qr_result_collector_if: result-row input stream and element read port.
// Rev 1.0
// ============================================================================
interface qr_result_collector_if #(
   parameter int DATA_LENGTH = 13,
   parameter int N_ROW       = 8,
   parameter int N_COL       = 4
);
   localparam int ROW_W = $clog2(N_ROW);
   localparam int COL_W = $clog2(N_COL);

   logic                         res_valid;
   logic [N_COL*DATA_LENGTH-1:0] res_row;
   logic                         rd_valid;
   logic                         rd_ready;
   logic [DATA_LENGTH-1:0]       rd_data;
   logic [ROW_W-1:0]             rd_row;
   logic [COL_W-1:0]             rd_col;

   // collector side
   modport slave (
      input  res_valid, res_row, rd_ready,
      output rd_valid, rd_data, rd_row, rd_col
   );

   // core / consumer side
   modport master (
      output res_valid, res_row, rd_ready,
      input  rd_valid, rd_data, rd_row, rd_col
   );
endinterface
`default_nettype wire

// File: rtl/qr_result_collector.sv
`default_nettype none
// ============================================================================
// qr_result_collector: captures the QR_CORDIC 8x4 result matrix, measures
// start-to-first-result latency and drains it element-wise. Rev 1.0
// ============================================================================
module qr_result_collector #(
   parameter int DATA_LENGTH = 13,
   parameter int N_ROW       = 8,
   parameter int N_COL       = 4,
   parameter int CNT_W       = 9
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   qr_result_collector_if.slave     bus,
   output logic [CNT_W-1:0]         lat_cycles,
   output logic                     busy,
   output logic                     done,
   output logic                     err_overrun
);
   localparam int ROW_W  = $clog2(N_ROW);
   localparam int COL_W  = $clog2(N_COL);
   localparam int ELEM_W = ROW_W + COL_W;
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(N_ROW - 1);
   localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(N_ROW * N_COL - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_CAPTURE = 2'd2,
      S_DRAIN   = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       lat_q, lat_d;
   logic [ROW_W-1:0]       row_ptr_q, row_ptr_d;
   logic [ELEM_W-1:0]      elem_q, elem_d;
   logic                   rd_valid_q, rd_valid_d;
   logic [DATA_LENGTH-1:0] rd_data_q, rd_data_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   wr_en;
   logic [ROW_W-1:0]       wr_row;
   logic [CNT_W-1:0]       cnt_inc;

   logic [DATA_LENGTH-1:0] buf_q [N_ROW][N_COL];

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lat_d      = lat_q;
      row_ptr_d  = row_ptr_q;
      elem_d     = elem_q;
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      done_d     = 1'b0;
      err_d      = err_q;
      wr_en      = 1'b0;
      wr_row     = row_ptr_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_WAIT;
               cnt_d   = '0;
               lat_d   = '0;
               err_d   = 1'b0;
            end
         end
         S_WAIT: begin
            if (bus.res_valid) begin
               lat_d     = cnt_inc;
               wr_en     = 1'b1;
               wr_row    = '0;
               row_ptr_d = ROW_W'(1);
               state_d   = S_CAPTURE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_CAPTURE: begin
            if (bus.res_valid) begin
               wr_en     = 1'b1;
               row_ptr_d = row_ptr_q + ROW_W'(1);
               if (row_ptr_q == LAST_ROW) begin
                  // row 0 is already in the buffer, so the first element can be presented now
                  state_d    = S_DRAIN;
                  row_ptr_d  = '0;
                  elem_d     = '0;
                  rd_valid_d = 1'b1;
                  rd_data_d  = buf_q[0][0];
               end
            end
         end
         S_DRAIN: begin
            if (bus.res_valid) begin
               err_d = 1'b1;
            end
            if (bus.rd_ready) begin
               if (elem_q == LAST_ELEM) begin
                  rd_valid_d = 1'b0;
                  done_d     = 1'b1;
                  elem_d     = '0;
                  state_d    = S_IDLE;
               end else begin
                  elem_d    = elem_q + ELEM_W'(1);
                  rd_data_d = buf_q[elem_d[ELEM_W-1:COL_W]][elem_d[COL_W-1:0]];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // busy covers the done cycle even though the state is already IDLE
      busy_d = (state_d != S_IDLE) || done_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         lat_q      <= '0;
         row_ptr_q  <= '0;
         elem_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lat_q      <= lat_d;
         row_ptr_q  <= row_ptr_d;
         elem_q     <= elem_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int c = 0; c < N_COL; c++) begin
            buf_q[wr_row][c] <= bus.res_row[c*DATA_LENGTH +: DATA_LENGTH];
         end
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_row   = elem_q[ELEM_W-1:COL_W];
   assign bus.rd_col   = elem_q[COL_W-1:0];
   assign lat_cycles   = lat_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err_overrun  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_qr_result_collector.sv
`default_nettype none
// ============================================================================
// tb_qr_result_collector: scoreboard bench for the result collector.
// Rev 1.0
// ============================================================================
module tb_qr_result_collector;
   localparam int DL = 13;
   localparam int NR = 8;
   localparam int NC = 4;
   localparam int CW = 9;

   typedef logic [NC*DL-1:0] row_t;
   typedef struct packed {
      logic [2:0]    row;
      logic [1:0]    col;
      logic [DL-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] lat_cycles;
   logic          busy;
   logic          done;
   logic          err_overrun;

   exp_t exp_q[$];
   row_t mat [NR];
   int   tests_run = 0;
   int   tests_failed = 0;

   qr_result_collector_if #(.DATA_LENGTH(DL), .N_ROW(NR), .N_COL(NC)) bus ();

   qr_result_collector #(.DATA_LENGTH(DL), .N_ROW(NR), .N_COL(NC), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .bus         (bus),
      .lat_cycles  (lat_cycles),
      .busy        (busy),
      .done        (done),
      .err_overrun (err_overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic fill_random();
      for (int r = 0; r < NR; r++) mat[r] = {$urandom, $urandom};
   endtask

   // Feeds the matrix after wait_n idle cycles, with an optional gap before gap_row.
   task automatic run_capture(input int wait_n, input int gap_row, input int gap_len);
      exp_t e;
      bus.res_valid = 1'b0;
      repeat (wait_n) tick();
      for (int r = 0; r < NR; r++) begin
         if (r == gap_row) begin
            bus.res_valid = 1'b0;
            bus.res_row   = '1;
            repeat (gap_len) tick();
         end
         bus.res_valid = 1'b1;
         bus.res_row   = mat[r];
         for (int c = 0; c < NC; c++) begin
            e.row  = 3'(r);
            e.col  = 2'(c);
            e.data = mat[r][c*DL +: DL];
            exp_q.push_back(e);
         end
         tick();
      end
      bus.res_valid = 1'b0;
      bus.res_row   = '0;
   endtask

   // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: overrun + start injection,
   // 3: reset after 10 accepted elements
   task automatic test_drain(input int mode, input string tag);
      int            cyc = 0;
      int            accepted = 0;
      bit            held = 1'b0;
      logic [DL+4:0] hv = '0;
      logic [DL+4:0] got;
      while (exp_q.size() > 0) begin
         if (cyc >= 400) begin
            tests_run++; tests_failed++;
            $display("FAIL %s drain_timeout: got %0d elements left, expected 0", tag, exp_q.size());
            exp_q.delete();
            break;
         end
         if (mode == 3 && accepted == 10) begin
            #1 rst_n = 1'b0;
            #1;
            tests_run++;
            if ({bus.rd_valid, busy} !== 2'b00) begin
               tests_failed++;
               $display("FAIL %s async_reset: got rd_valid=%b busy=%b, expected 0 0", tag, bus.rd_valid, busy);
            end
            exp_q.delete();
            bus.rd_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               if (i == 2) rst_n = 1'b1;
               tick();
               tests_run++;
               if ({done, busy, bus.rd_valid, lat_cycles} !== '0) begin
                  tests_failed++;
                  $display("FAIL %s post_reset: got done=%b busy=%b rd_valid=%b lat=%0d, expected all 0",
                           tag, done, busy, bus.rd_valid, lat_cycles);
               end
            end
            return;
         end
         bus.rd_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         if (mode == 2) begin
            bus.res_valid = (cyc == 5);
            bus.res_row   = '1;
            start         = (cyc == 8);
         end
         got = {bus.rd_row, bus.rd_col, bus.rd_data};
         tests_run++;
         if (bus.rd_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s drain_flags cyc%0d: got rd_valid=%b done=%b busy=%b, expected 1 0 1",
                     tag, cyc, bus.rd_valid, done, busy);
         end
         if (held) begin
            tests_run++;
            if (got !== hv) begin
               tests_failed++;
               $display("FAIL %s stall_hold cyc%0d: got %h, expected %h", tag, cyc, got, hv);
            end
         end
         if (bus.rd_ready) begin
            tests_run++;
            if (got !== exp_q[0]) begin
               tests_failed++;
               $display("FAIL %s elem%0d: got row=%0d col=%0d data=%h, expected row=%0d col=%0d data=%h",
                        tag, accepted, bus.rd_row, bus.rd_col, bus.rd_data,
                        exp_q[0].row, exp_q[0].col, exp_q[0].data);
            end
            void'(exp_q.pop_front());
            accepted++;
            held = 1'b0;
         end else begin
            held = 1'b1;
            hv   = got;
         end
         tick();
         cyc++;
      end
      bus.rd_ready  = 1'b0;
      bus.res_valid = 1'b0;
      start         = 1'b0;
      tests_run++;
      if ({done, busy, bus.rd_valid} !== 3'b110) begin
         tests_failed++;
         $display("FAIL %s done_cycle: got done=%b busy=%b rd_valid=%b, expected 1 1 0", tag, done, busy, bus.rd_valid);
      end
      tick();
      tests_run++;
      if ({done, busy} !== 2'b00) begin
         tests_failed++;
         $display("FAIL %s after_done: got done=%b busy=%b, expected 0 0", tag, done, busy);
      end
      tests_run++;
      if (err_overrun !== (mode == 2)) begin
         tests_failed++;
         $display("FAIL %s err_overrun: got %b, expected %b", tag, err_overrun, (mode == 2));
      end
      if (mode == 0) begin
         tests_run++;
         if (cyc != NR * NC) begin
            tests_failed++;
            $display("FAIL %s drain_cycles: got %0d, expected %0d", tag, cyc, NR * NC);
         end
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({bus.rd_valid, bus.rd_data, bus.rd_row, bus.rd_col, lat_cycles, busy, done, err_overrun} !== '0) begin
         tests_failed++;
         $display("FAIL reset_async: got rd_valid=%b data=%h busy=%b done=%b err=%b lat=%0d, expected all 0",
                  bus.rd_valid, bus.rd_data, busy, done, err_overrun, lat_cycles);
      end
      bus.res_valid = 1'b1;
      bus.res_row   = '1;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      bus.res_valid = 1'b0;
      tests_run++;
      if ({bus.rd_valid, busy, done, err_overrun, lat_cycles} !== '0) begin
         tests_failed++;
         $display("FAIL reset_idle: got rd_valid=%b busy=%b done=%b err=%b lat=%0d, expected all 0",
                  bus.rd_valid, busy, done, err_overrun, lat_cycles);
      end
   endtask

   task automatic test_basic(input string tag);
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) mat[r][c*DL +: DL] = DL'(4 * r + c);
      do_start();
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s busy_after_start: got %b, expected 1", tag, busy);
      end
      run_capture(30, -1, 0);
      tests_run++;
      if (lat_cycles !== 9'd31) begin
         tests_failed++;
         $display("FAIL %s lat_cycles: got %0d, expected 31", tag, lat_cycles);
      end
      test_drain(0, tag);
   endtask

   task automatic test_negative_gaps();
      for (int r = 0; r < NR; r++) begin
         mat[r][0*DL +: DL] = 13'h1FFF;
         mat[r][1*DL +: DL] = 13'h1000;
         mat[r][2*DL +: DL] = DL'(r * 100 + 7);
         mat[r][3*DL +: DL] = DL'(13'h1FFF - r);
      end
      do_start();
      run_capture(5, 4, 2);
      tests_run++;
      if (lat_cycles !== 9'd6) begin
         tests_failed++;
         $display("FAIL neg_gaps lat_cycles: got %0d, expected 6", lat_cycles);
      end
      test_drain(0, "neg_gaps");
   endtask

   task automatic test_backpressure();
      fill_random();
      do_start();
      run_capture(3, -1, 0);
      tests_run++;
      if (lat_cycles !== 9'd4) begin
         tests_failed++;
         $display("FAIL backpressure lat_cycles: got %0d, expected 4", lat_cycles);
      end
      test_drain(1, "backpressure");
   endtask

   task automatic test_overrun();
      fill_random();
      do_start();
      run_capture(0, -1, 0);
      tests_run++;
      if (lat_cycles !== 9'd1) begin
         tests_failed++;
         $display("FAIL overrun lat_cycles: got %0d, expected 1", lat_cycles);
      end
      test_drain(2, "overrun");
      repeat (3) tick();
      tests_run++;
      if ({err_overrun, busy, bus.rd_valid} !== 3'b100) begin
         tests_failed++;
         $display("FAIL overrun idle_after: got err=%b busy=%b rd_valid=%b, expected 1 0 0",
                  err_overrun, busy, bus.rd_valid);
      end
   endtask

   task automatic test_saturation();
      fill_random();
      do_start();
      tests_run++;
      if (err_overrun !== 1'b0) begin
         tests_failed++;
         $display("FAIL saturation err_clear_on_start: got %b, expected 0", err_overrun);
      end
      run_capture(600, -1, 0);
      tests_run++;
      if (lat_cycles !== 9'd511) begin
         tests_failed++;
         $display("FAIL saturation lat_cycles: got %0d, expected 511", lat_cycles);
      end
      test_drain(0, "saturation");
   endtask

   task automatic test_reset_mid_drain();
      fill_random();
      do_start();
      run_capture(2, -1, 0);
      test_drain(3, "reset_mid");
      test_basic("after_reset");
   endtask

   initial begin
      bus.res_valid = 1'b0;
      bus.res_row   = '0;
      bus.rd_ready  = 1'b0;
      test_reset();
      test_basic("basic");
      test_negative_gaps();
      test_backpressure();
      test_overrun();
      test_saturation();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/qr_result_collector.md
Name: qr_result_collector

Overview:
- Sits on the output side of QR_CORDIC and is the on-chip counterpart of the bench checker.
- Captures the 8x4 result matrix streamed row-per-beat on the 52-bit out bus while out_vallid is high.
- Measures the start-to-first-result latency.
- Drains the stored matrix one 13-bit element at a time over a valid/ready read port, for host readout or a downstream block.

Parameters:
- DATA_LENGTH, 13, bit width of one matrix element.
- N_ROW, 8, rows per result matrix.
- N_COL, 4, elements per row; the row bus width is N_COL*DATA_LENGTH.
- CNT_W, 9, width of the latency counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse marking the end of the input stream to the core; arms capture.
- res_valid  input  1  connected to core out_vallid.
- res_row  input  N_COL*DATA_LENGTH  core out bus. Element c occupies bits [c*DATA_LENGTH +: DATA_LENGTH].
- rd_valid  output  1  rd_data holds a valid element.
- rd_ready  input  1  consumer accepts an element when rd_valid && rd_ready.
- rd_data  output  DATA_LENGTH  current element, two's complement, passed through unmodified.
- rd_row  output  3  row index of rd_data.
- rd_col  output  2  column index of rd_data.
- lat_cycles  output  CNT_W  measured latency, held until the next accepted start.
- busy  output  1  high in WAIT, CAPTURE and DRAIN.
- done  output  1  one-cycle pulse after the last element is accepted.
- err_overrun  output  1  sticky error flag; cleared by reset or an accepted start.

Behaviour:
- Reset (async, rst_n low): all of the following go to 0 immediately: state=IDLE, rd_valid, rd_data, rd_row, rd_col, lat_cycles, busy, done, err_overrun, row pointer, element pointer. Buffer contents are don't-care.
- Reset mid-operation abandons the matrix. No done pulse is generated.
- States: IDLE, WAIT, CAPTURE, DRAIN.
- IDLE:
  - start=1 moves to WAIT. On that edge, the counter and err_overrun clear.
  - res_valid in IDLE is ignored.
- WAIT:
  - Each cycle with res_valid=0 increments the counter. The counter saturates at 2^CNT_W-1 and does not wrap.
  - On the first cycle with res_valid=1: lat_cycles <= counter+1 (saturating), res_row is stored as row 0, row pointer becomes 1, and the state moves to CAPTURE.
  - Example: res_valid high on the cycle directly after start gives lat_cycles=1.
- CAPTURE:
  - Each cycle with res_valid=1 stores res_row at the row pointer and increments the pointer.
  - Cycles with res_valid=0 are gaps: nothing is stored and it is not an error.
  - Storing row N_ROW-1 moves to DRAIN. rd_valid rises on the next cycle with row 0, col 0.
- DRAIN:
  - Element order is row-major: row 0 col 0..3, then row 1, and so on up to row 7 col 3.
  - rd_data, rd_row and rd_col stay stable while rd_valid=1 and rd_ready=0.
  - On acceptance, the next element is presented the following cycle with no bubble. Back-to-back rd_ready gives N_ROW*N_COL=32 elements in 32 cycles.
  - Acceptance of element (7,3): rd_valid drops, done pulses 1 cycle, state returns to IDLE.
- err_overrun: set when res_valid=1 while in DRAIN. The incoming data is dropped; the drain continues unaffected.
- start while busy is ignored. It does not restart, clear, or flag anything.
- busy is registered: high from the cycle after start is accepted until the cycle done pulses, inclusive of the done cycle.
- Buffer is N_ROW x N_COL registers of DATA_LENGTH bits. Row-pointer and column-pointer wrap is never exercised, because state changes at the boundaries.

Test Plan:
1. Basic capture and drain:
   - Stimulus: reset, start, res_valid low for 30 cycles, then 8 consecutive rows where row r = {13'd(4r+3), 13'd(4r+2), 13'd(4r+1), 13'd(4r)}; rd_ready held high.
   - Required: lat_cycles=31; rd_data reads 0,1,...,31 over 32 consecutive cycles with correct rd_row/rd_col; done pulses once; busy falls.
2. Negative values and gaps:
   - Stimulus: rows containing 13'h1FFF (-1) and 13'h1000 (-4096); res_valid deasserted for 2 cycles between rows 3 and 4.
   - Required: all 32 elements are bit-exact; gap cycles are not captured; no error flagged.
3. Backpressure:
   - Stimulus: rd_ready toggles 1,0,0,1 repeatedly.
   - Required: rd_data/rd_row/rd_col are held during stalls; no element is duplicated or skipped; done arrives only after element (7,3) is accepted.
4. Overrun and ignored start:
   - Stimulus: during DRAIN, pulse res_valid for 1 cycle and pulse start.
   - Required: err_overrun=1 and stays set; drain output is unchanged; state does not restart. A start in IDLE then clears err_overrun.
5. Latency saturation:
   - Stimulus: start, then res_valid held low for 600 cycles.
   - Required: when res_valid first rises, lat_cycles=511.
6. Reset mid-drain:
   - Stimulus: assert rst_n=0 after 10 elements have been accepted.
   - Required: rd_valid and busy go to 0 immediately and asynchronously; no done pulse. A subsequent full sequence behaves as in scenario 1.
